mcif_rd_unpack: RTL
===================

Name: mcif_rd_unpack

Overview:
- Width-down converter directly downstream of the MCIF read-data alignment stage.
- Consumes full AXI-width read beats and emits them as a stream of narrower words, least-significant lane first.
- A per-transfer command gives the exact number of output words, so the tail of the last beat is discarded and the final word is flagged.
- Feeds the VPU-side consumers that work on sub-beat word widths.

Parameters:
DIN_W, `AXI_DATA_WIDTH, input beat width in bits
DOUT_W, 64, output word width; DIN_W/DOUT_W = R must be a power of two, R >= 2
LEN_W, 16, width of the command length field

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
cmd_vld  input  1  transfer command valid
cmd_len  input  LEN_W  number of DOUT_W words to emit for this transfer
cmd_rdy  output  1  command accepted when cmd_vld && cmd_rdy
data_in_vld  input  1  input beat valid
data_in  input  DIN_W  input beat from alignment stage
data_in_rdy  output  1  beat accepted when data_in_vld && data_in_rdy
data_out_vld  output  1  output word valid
data_out  output  DOUT_W  output word
data_out_last  output  1  final word of current transfer
data_out_rdy  input  1  downstream ready
busy  output  1  transfer in progress (state != IDLE)

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n; all state clears on assertion, independent of clk.
- Reset values: state IDLE, cmd_rdy=1, data_in_rdy=0, data_out_vld=0, data_out_last=0, busy=0. Hold register, lane index and remaining count are 0. data_out reads 0.
- Internal state:
  - hold register, DIN_W bits
  - lane index sub, log2(R) bits
  - remaining word count rem, LEN_W bits
- FSM states: IDLE, LOAD, SEND.
- IDLE:
  - cmd_rdy=1.
  - On command handshake with cmd_len=0: stay IDLE. No beat consumed, no output.
  - On command handshake with cmd_len>0: rem<=cmd_len, go to LOAD.
- LOAD:
  - data_in_rdy=1, cmd_rdy=0, data_out_vld=0.
  - On input handshake: hold<=data_in, sub<=0, go to SEND.
  - Input starvation: remain in LOAD indefinitely.
- SEND:
  - data_out_vld=1; data_out = hold[sub*DOUT_W +: DOUT_W]; data_out_last = (rem==1).
  - On output handshake:
    - rem decrements.
    - If rem==1: go to IDLE. Unused upper lanes of the held beat are discarded.
    - Else if sub==R-1: next beat needed (see fast reload below).
    - Else: sub<=sub+1.
- Fast reload, no bubble at beat boundaries:
  - Applies in SEND when sub==R-1 and rem>1.
  - data_in_rdy = data_out_rdy (combinational).
  - Output and input handshake in the same cycle: hold<=data_in, sub<=0, stay in SEND.
  - Output handshake without input: go to LOAD.
- Elsewhere in SEND, data_in_rdy=0.
- Stability: while data_out_vld && !data_out_rdy, data_out and data_out_last hold stable.
- Latency:
  - Command accepted at cycle T; beat accepted at T+1 at the earliest.
  - First word valid the cycle after beat acceptance.
  - With continuous valid/ready, steady state is 1 word per cycle.
  - After the last handshake, cmd_rdy is 1 on the next cycle, giving a 1-cycle gap between transfers.
- Beats consumed per transfer = ceil(cmd_len/R). Surplus beats from upstream are never accepted.
- Wrap: rem never underflows. sub wraps only via reload.
- Reset mid-transfer:
  - Immediate return to IDLE. Held data is lost; no further outputs.
  - Upstream/downstream reset together with this block.
- Commands arriving while busy are held off by cmd_rdy=0. cmd_len is sampled only at the handshake.

Test Plan:
1. R=4, cmd_len=8, beats B0,B1 presented continuously, data_out_rdy=1 -> 8 words B0[63:0],B0[127:64],…,B1[255:192] on 8 consecutive cycles; last only on the 8th; exactly 2 input handshakes; busy drops the next cycle.
2. cmd_len=5 -> 2 beats consumed; words B0 lanes 0–3 then B1 lane 0 with last=1; B1 lanes 1–3 never appear; a third offered beat is not accepted (data_in_rdy=0).
3. cmd_len=0 -> cmd_rdy stays 1, data_in_rdy never asserts, no output; next command accepted the following cycle.
4. cmd_len=12, data_out_rdy toggling 1/0 every cycle -> data_out/last stable during stalls; 12 words in order; input accepted only on sub=3 output handshakes or in LOAD.
5. cmd_len=8, data_in_vld dropped for 3 cycles before the second beat -> data_out_vld=0 in LOAD for those cycles; word order unchanged.
6. rst_n asserted asynchronously after word 3 of cmd_len=8 -> outputs go to reset values immediately; after release, new cmd_len=4 produces 4 words from a fresh beat only.

Source files
------------

// File: rtl/mcif_rd_unpack.sv
// mcif_rd_unpack
// Width-down converter that sits after the MCIF read-data alignment stage.
// Takes full-width read beats and emits them as DOUT_W words, least-significant
// lane first. A per-transfer command gives the exact number of words to emit.
// Lanes of the final beat beyond that count are dropped, and the last word
// is flagged.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cmd_vld/cmd_rdy, cmd_len          transfer command (word count)
//   data_in_vld/data_in_rdy, data_in  full-width input beats
//   data_out_vld/data_out_rdy         narrow output words
//   data_out, data_out_last           word payload and end-of-transfer flag
//   busy                              transfer in progress
//
// DIN_W/DOUT_W must be a power of two and at least 2.
//
// state | meaning
// IDLE  | waiting for a command, cmd_rdy high
// LOAD  | waiting for the next input beat, no output
// SEND  | presenting lane sub of the held beat

`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 256
`endif

module mcif_rd_unpack #(
  parameter int DIN_W  = `AXI_DATA_WIDTH,
  parameter int DOUT_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_rdy,
  input  logic              data_in_vld,
  input  logic [DIN_W-1:0]  data_in,
  output logic              data_in_rdy,
  output logic              data_out_vld,
  output logic [DOUT_W-1:0] data_out,
  output logic              data_out_last,
  input  logic              data_out_rdy,
  output logic              busy
);

  localparam int R     = DIN_W / DOUT_W;
  localparam int SUB_W = $clog2(R);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(R - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t            state;
  logic [DIN_W-1:0]  hold;
  logic [SUB_W-1:0]  sub;
  logic [LEN_W-1:0]  rem;

  logic [DOUT_W-1:0] lane [R];
  logic              is_last;
  logic              reload;

  for (genvar g = 0; g < R; g++) begin : g_lane
    assign lane[g] = hold[g*DOUT_W +: DOUT_W];
  end

  assign is_last = (rem == LEN_ONE);
  // On the top lane with more words still owed, the next beat can be taken
  // in the same cycle the current word leaves, so beat boundaries cost no bubble.
  assign reload  = (state == SEND) && (sub == SUB_LAST) && (rem > LEN_ONE);

  assign cmd_rdy       = (state == IDLE);
  assign busy          = (state != IDLE);
  assign data_out_vld  = (state == SEND);
  assign data_out_last = (state == SEND) && is_last;
  assign data_out      = lane[sub];
  assign data_in_rdy   = (state == LOAD) || (reload && data_out_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
      sub   <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A zero-length command is accepted and retired with no effect.
          if (cmd_vld && (cmd_len != '0)) begin
            rem   <= cmd_len;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (data_in_vld) begin
            hold  <= data_in;
            sub   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (data_out_rdy) begin
            rem <= rem - LEN_ONE;
            if (is_last) begin
              state <= IDLE;
            end else if (sub == SUB_LAST) begin
              if (data_in_vld) begin
                hold <= data_in;
                sub  <= '0;
              end else begin
                state <= LOAD;
              end
            end else begin
              sub <= sub + SUB_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
